// File: rtl/txn_capture_fifo.sv
// Passive valid/ready snoop that timestamps accepted beats into a first-word-fall-through FIFO.
// Optional sequence-number checker enabled by defining TXN_CAPTURE_SEQ_CHECK_EN.
module txn_capture_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int TS_WIDTH   = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     snoop_valid,
   input  logic                     snoop_ready,
   input  logic [DATA_WIDTH-1:0]    snoop_data,
   input  logic                     rd_en,
   output logic                     rd_valid,
   output logic [DATA_WIDTH-1:0]    rd_data,
   output logic [TS_WIDTH-1:0]      rd_ts,
   output logic [$clog2(DEPTH):0]   level,
   output logic [15:0]              overflow_cnt
`ifdef TXN_CAPTURE_SEQ_CHECK_EN
   ,
   output logic                     seq_err
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [TS_WIDTH-1:0]   ts_cnt;
   logic [DATA_WIDTH-1:0] data_mem [DEPTH];
   logic [TS_WIDTH-1:0]   ts_mem   [DEPTH];

   logic capture;
   logic full;
   logic pop;
   logic push;
   logic drop;

   // A pop in the same cycle frees the slot, so a full FIFO still accepts the capture.
   assign capture  = snoop_valid & snoop_ready & enable;
   assign full     = (level == FULL_LEVEL);
   assign rd_valid = (level != '0);
   assign pop      = rd_en & rd_valid;
   assign push     = capture & (~full | pop);
   assign drop     = capture & full & ~pop;

   assign rd_data  = data_mem[rd_ptr];
   assign rd_ts    = ts_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr] <= snoop_data;
         ts_mem[wr_ptr]   <= ts_cnt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts_cnt       <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         overflow_cnt <= '0;
      end else begin
         ts_cnt <= ts_cnt + 1'b1;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (drop && overflow_cnt != 16'hFFFF) begin
            overflow_cnt <= overflow_cnt + 16'd1;
         end
      end
   end

`ifdef TXN_CAPTURE_SEQ_CHECK_EN
   logic [15:0] prev_seq;
   logic        seq_valid;

   // Dropped beats still advance the sequence; a low enable forgets history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_seq  <= '0;
         seq_valid <= 1'b0;
         seq_err   <= 1'b0;
      end else begin
         seq_err <= 1'b0;
         if (capture) begin
            seq_err   <= seq_valid && (snoop_data[15:0] != prev_seq + 16'd1);
            prev_seq  <= snoop_data[15:0];
            seq_valid <= 1'b1;
         end else if (!enable) begin
            seq_valid <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_txn_capture_fifo.sv
// Self-checking bench for txn_capture_fifo: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_txn_capture_fifo;

   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int TW    = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic          snoop_valid = 1'b0;
   logic          snoop_ready = 1'b0;
   logic [DW-1:0] snoop_data = '0;
   logic          rd_en = 1'b0;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   logic [TW-1:0] rd_ts;
   logic [$clog2(DEPTH):0] level;
   logic [15:0]   overflow_cnt;
`ifdef TXN_CAPTURE_SEQ_CHECK_EN
   logic          seq_err;
`endif

   txn_capture_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TS_WIDTH(TW)) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .snoop_valid  (snoop_valid),
      .snoop_ready  (snoop_ready),
      .snoop_data   (snoop_data),
      .rd_en        (rd_en),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .rd_ts        (rd_ts),
      .level        (level),
      .overflow_cnt (overflow_cnt)
`ifdef TXN_CAPTURE_SEQ_CHECK_EN
      ,
      .seq_err      (seq_err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic [TW-1:0] ts;
   } entry_t;

   entry_t      q[$];
   logic [TW-1:0] m_ts;
   int          m_ovf;
   logic [15:0] m_prev;
   bit          m_have;
   bit          m_seq_err;
   int          vectors;
   int          miscompares;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      q.delete();
      m_ts      = '0;
      m_ovf     = 0;
      m_have    = 1'b0;
      m_prev    = '0;
      m_seq_err = 1'b0;
   endtask

   // Reference behaviour of one clock edge, expressed as queue operations.
   task automatic updateModel(input logic v, input logic r, input logic e,
                              input logic [DW-1:0] d, input logic rd);
      bit cap;
      bit do_pop;
      bit was_full;
      entry_t ent;
      cap      = v && r && e;
      do_pop   = rd && (q.size() != 0);
      was_full = (q.size() == DEPTH);
      m_seq_err = 1'b0;
      if (cap) begin
         if (m_have && d[15:0] != 16'(m_prev + 16'd1)) m_seq_err = 1'b1;
         m_prev = d[15:0];
         m_have = 1'b1;
      end else if (!e) begin
         m_have = 1'b0;
      end
      if (do_pop) void'(q.pop_front());
      if (cap) begin
         if (!was_full || do_pop) begin
            ent.data = d;
            ent.ts   = m_ts;
            q.push_back(ent);
         end else if (m_ovf < 65535) begin
            m_ovf++;
         end
      end
      m_ts = m_ts + 1'b1;
   endtask

   task automatic compareAll();
      checkOutput("rd_valid", 64'(rd_valid), 64'(q.size() != 0));
      checkOutput("level", 64'(level), 64'(q.size()));
      checkOutput("overflow_cnt", 64'(overflow_cnt), 64'(m_ovf));
      if (q.size() != 0) begin
         checkOutput("rd_data", 64'(rd_data), 64'(q[0].data));
         checkOutput("rd_ts", 64'(rd_ts), 64'(q[0].ts));
      end
`ifdef TXN_CAPTURE_SEQ_CHECK_EN
      checkOutput("seq_err", 64'(seq_err), 64'(m_seq_err));
`endif
   endtask

   // Called at a falling edge: drive, let one rising edge pass, then compare.
   task automatic applyStimulus(input logic v, input logic r, input logic e,
                                input logic [DW-1:0] d, input logic rd);
      snoop_valid = v;
      snoop_ready = r;
      enable      = e;
      snoop_data  = d;
      rd_en       = rd;
      @(posedge clk);
      updateModel(v, r, e, d, rd);
      @(negedge clk);
      compareAll();
   endtask

   task automatic beat(input logic [DW-1:0] d);
      applyStimulus(1'b1, 1'b1, 1'b1, d, 1'b0);
   endtask

   task automatic drain(input int cycles);
      for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, 1'b1, '0, 1'b1);
   endtask

   // Reset pulse placed strictly between rising edges to exercise the async path.
   task automatic asyncReset();
      snoop_valid = 1'b0;
      snoop_ready = 1'b0;
      enable      = 1'b0;
      rd_en       = 1'b0;
      #2 rst = 1'b1;
      #1;
      checkOutput("async_rst_rd_valid", 64'(rd_valid), 64'd0);
      checkOutput("async_rst_level", 64'(level), 64'd0);
      checkOutput("async_rst_overflow", 64'(overflow_cnt), 64'd0);
      modelReset();
      #1 rst = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      modelReset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checkOutput("reset_rd_valid", 64'(rd_valid), 64'd0);
      checkOutput("reset_level", 64'(level), 64'd0);
      checkOutput("reset_overflow", 64'(overflow_cnt), 64'd0);

      $display("[TB] three beats starting at timestamp 5");
      while (m_ts != 5) applyStimulus(1'b0, 1'b0, 1'b1, '0, 1'b0);
      beat(32'hA);
      checkOutput("first_ts", 64'(rd_ts), 64'd5);
      beat(32'hB);
      beat(32'hC);
      checkOutput("peak_level", 64'(level), 64'd3);
      drain(4);
      checkOutput("drained_valid", 64'(rd_valid), 64'd0);

      $display("[TB] beats without handshake or with enable low");
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b1, DW'(i), 1'b0);
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, DW'(i), 1'b0);
      checkOutput("ignored_level", 64'(level), 64'd0);
      checkOutput("ignored_overflow", 64'(overflow_cnt), 64'd0);

      $display("[TB] overfill with 20 beats");
      for (int i = 0; i < 20; i++) beat(DW'(i));
      checkOutput("overfill_level", 64'(level), 64'd16);
      checkOutput("overfill_overflow", 64'(overflow_cnt), 64'd4);
      drain(17);
      checkOutput("overfill_drained", 64'(level), 64'd0);

      $display("[TB] push and pop while full");
      for (int i = 0; i < 16; i++) beat(DW'(100 + i));
      applyStimulus(1'b1, 1'b1, 1'b1, 32'hBEEF, 1'b1);
      checkOutput("full_pushpop_level", 64'(level), 64'd16);
      checkOutput("full_pushpop_overflow", 64'(overflow_cnt), 64'd4);
      checkOutput("full_pushpop_tail", 64'(q[$].data), 64'hBEEF);
      drain(17);

      $display("[TB] reset in the middle of traffic");
      for (int i = 0; i < 4; i++) beat(DW'(200 + i));
      asyncReset();
      beat(DW'(300));
      checkOutput("post_reset_ts", 64'(rd_ts), 64'd0);
      for (int i = 1; i < 4; i++) beat(DW'(300 + i));
      drain(5);

`ifdef TXN_CAPTURE_SEQ_CHECK_EN
      $display("[TB] sequence gap detection");
      asyncReset();
      beat(DW'(1));
      beat(DW'(2));
      beat(DW'(4));
      checkOutput("seq_gap_pulse", 64'(seq_err), 64'd1);
      beat(DW'(5));
      checkOutput("seq_no_pulse", 64'(seq_err), 64'd0);
      drain(5);
`endif

      $display("[TB] randomized traffic");
      for (int i = 0; i < 3000; i++) begin
         logic v;
         logic r;
         logic e;
         logic rd;
         logic [DW-1:0] d;
         v  = ($urandom_range(0, 3) != 0);
         r  = ($urandom_range(0, 3) != 0);
         e  = ($urandom_range(0, 9) != 0);
         rd = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         d  = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'(m_prev + 16'd1);
         applyStimulus(v, r, e, d, rd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/txn_capture_fifo.md
Name: txn_capture_fifo

Overview:
- Synthesizable snoop-and-buffer stage between the bench's stimulus side and its observation side.
- Passively taps a valid/ready stream that a driver presents to the DUT.
- Stamps each accepted beat with a free-running cycle count and queues it in a first-word-fall-through FIFO.
- The monitor drains the FIFO at its own pace, so observation never back-pressures the DUT interface and beats are never missed silently.

Parameters:
DATA_WIDTH, 32, width of snooped payload
DEPTH, 16, FIFO entries; power of two, >= 2
TS_WIDTH, 32, width of timestamp counter and stored stamp

Ports:
clk  in  1  clock; all logic rising-edge
rst  in  1  reset, asynchronous, active-high
enable  in  1  capture enable; 0 = ignore stream
snoop_valid  in  1  tapped stream valid
snoop_ready  in  1  tapped stream ready
snoop_data  in  DATA_WIDTH  tapped stream payload
rd_en  in  1  monitor pop request
rd_valid  out  1  FIFO head holds a captured beat
rd_data  out  DATA_WIDTH  head payload
rd_ts  out  TS_WIDTH  head timestamp
level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow_cnt  out  16  beats dropped because FIFO full

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is asynchronous and active-high, with synchronous deassertion assumed upstream.
- Reset values: rd_valid=0, level=0, overflow_cnt=0, timestamp counter=0, read/write pointers=0. rd_data and rd_ts are don't-care while rd_valid=0.
- Timestamp counter: increments by 1 every cycle out of reset and wraps modulo 2^TS_WIDTH. It does not stop when enable=0.
- Capture event: snoop_valid & snoop_ready & enable sampled at a clk edge. The stored stamp is the counter value in that same cycle, i.e. before its increment.
- Passive tap: the block never drives snoop_ready and adds no combinational path onto the snooped signals.
- Write: on a capture event with FIFO not full, write {data, ts} at wr_ptr and advance wr_ptr modulo DEPTH.
- Drop: on a capture event with FIFO full and no pop that cycle, discard the beat and increment overflow_cnt. overflow_cnt saturates at 16'hFFFF and never wraps.
- FWFT read: rd_valid = (level != 0). rd_data/rd_ts show the head entry combinationally from storage.
  - Pop happens when rd_en & rd_valid.
  - rd_en while empty is ignored: no pointer change, no error.
- Latency: a beat captured at edge N appears on rd_valid/rd_data after edge N, i.e. it is visible in cycle N+1.
- Simultaneous push and pop:
  - Not full, not empty: level unchanged, both pointers advance.
  - Full: the pop frees a slot, so the capture is accepted and not dropped; level stays DEPTH, overflow_cnt unchanged.
  - Empty: no bypass. The pop is ignored because rd_valid=0, the push is written, and level becomes 1.
- Level arithmetic: level += push_accepted - pop_accepted. It never exceeds DEPTH and never underflows.
- Reset mid-operation: the FIFO is flushed immediately (asynchronous), counters clear, and in-flight beats are lost. This is not counted as overflow.
- Disable mid-stream: beats with enable=0 are neither stored nor counted. Entries already queued remain readable.

Optional Feature:
- Macro TXN_CAPTURE_SEQ_CHECK_EN.
- Defined:
  - Adds output seq_err (1 bit, reset 0).
  - Treats snoop_data[15:0] as a sequence number. seq_err pulses high for one cycle when a captured beat's number != previous captured number + 1 (mod 2^16).
  - The first capture after reset or after enable rises is never flagged.
  - Comparison applies to all capture events, including dropped ones.
- Undefined: the port and check logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then 3 beats (data 0xA, 0xB, 0xC) on consecutive cycles starting at timestamp 5, then drain with rd_en held high -> rd_data 0xA, 0xB, 0xC with rd_ts 5, 6, 7; level peaks at 3 and returns to 0; rd_valid drops after the third pop.
- DEPTH=16 with rd_en=0, 20 back-to-back captures of data 0..19 -> level=16, overflow_cnt=4; drain yields data 0..15 in order.
- FIFO full, capture and rd_en asserted in the same cycle -> no drop, level stays 16, overflow_cnt unchanged, new beat is the tail entry.
- Beats presented with snoop_ready=0, or with enable=0 -> level stays 0, overflow_cnt stays 0.
- 8 captures, rst asserted between clk edges after the 4th -> outputs clear asynchronously; after release level=0, rd_valid=0, and the timestamp restarts from 0.
- With TXN_CAPTURE_SEQ_CHECK_EN: sequence 1, 2, 4, 5 -> single seq_err pulse in the cycle after capturing 4; no pulse for 5.
